// File: rtl/reorder_buffer_mw_if.sv
// Handshake bundle between dispatch/execute/commit and reorder_buffer_mw.
// The exception signals exist only when ROB_EXCEPTION_EN is defined.
interface reorder_buffer_mw_if #(
    parameter int ROB_ADDR_WIDTH  = 5,
    parameter int REG_ADDR_WIDTH  = 7,
    parameter int ARCH_ADDR_WIDTH = 5,
    parameter int DISPATCH_WIDTH  = 2,
    parameter int RETIRE_WIDTH    = 2,
    parameter int COMPLETE_PORTS  = 2
);
    logic [DISPATCH_WIDTH-1:0]                 alloc_valid;
    logic [DISPATCH_WIDTH*ARCH_ADDR_WIDTH-1:0] alloc_arch;
    logic [DISPATCH_WIDTH*REG_ADDR_WIDTH-1:0]  alloc_dest;
    logic [DISPATCH_WIDTH*REG_ADDR_WIDTH-1:0]  alloc_old_dest;
    logic                                      alloc_ready;
    logic [DISPATCH_WIDTH*ROB_ADDR_WIDTH-1:0]  alloc_tag;
    logic [COMPLETE_PORTS-1:0]                 complete_valid;
    logic [COMPLETE_PORTS*ROB_ADDR_WIDTH-1:0]  complete_tag;
    logic [RETIRE_WIDTH-1:0]                   retire_valid;
    logic [RETIRE_WIDTH*ARCH_ADDR_WIDTH-1:0]   retire_arch;
    logic [RETIRE_WIDTH*REG_ADDR_WIDTH-1:0]    retire_dest;
    logic [RETIRE_WIDTH*REG_ADDR_WIDTH-1:0]    retire_old_dest;
    logic                                      flush_valid;
    logic [ROB_ADDR_WIDTH-1:0]                 flush_tag;
    logic                                      rb_valid;
    logic [ARCH_ADDR_WIDTH-1:0]                rb_arch;
    logic [REG_ADDR_WIDTH-1:0]                 rb_dest;
    logic [REG_ADDR_WIDTH-1:0]                 rb_old_dest;
    logic                                      rolling_back;
    logic [ROB_ADDR_WIDTH:0]                   count;
    logic                                      empty;
    logic                                      full;
`ifdef ROB_EXCEPTION_EN
    logic [COMPLETE_PORTS-1:0]                 complete_exc;
    logic                                      exc_valid;
    logic [ROB_ADDR_WIDTH-1:0]                 exc_tag;
`endif

    modport master (
`ifdef ROB_EXCEPTION_EN
        output complete_exc,
        input  exc_valid, exc_tag,
`endif
        output alloc_valid, alloc_arch, alloc_dest, alloc_old_dest,
        output complete_valid, complete_tag, flush_valid, flush_tag,
        input  alloc_ready, alloc_tag,
        input  retire_valid, retire_arch, retire_dest, retire_old_dest,
        input  rb_valid, rb_arch, rb_dest, rb_old_dest,
        input  rolling_back, count, empty, full
    );

    modport slave (
`ifdef ROB_EXCEPTION_EN
        input  complete_exc,
        output exc_valid, exc_tag,
`endif
        input  alloc_valid, alloc_arch, alloc_dest, alloc_old_dest,
        input  complete_valid, complete_tag, flush_valid, flush_tag,
        output alloc_ready, alloc_tag,
        output retire_valid, retire_arch, retire_dest, retire_old_dest,
        output rb_valid, rb_arch, rb_dest, rb_old_dest,
        output rolling_back, count, empty, full
    );
endinterface

// File: rtl/reorder_buffer_mw.sv
// Multi-issue reorder buffer: N-wide allocate, C completion ports, R-wide in-order retire and a
// one-entry-per-cycle rollback walk after a flush. ROB_EXCEPTION_EN adds precise exceptions.
module reorder_buffer_mw #(
    parameter int ROB_ADDR_WIDTH  = 5,
    parameter int REG_ADDR_WIDTH  = 7,
    parameter int ARCH_ADDR_WIDTH = 5,
    parameter int DISPATCH_WIDTH  = 2,
    parameter int RETIRE_WIDTH    = 2,
    parameter int COMPLETE_PORTS  = 2
) (
    input logic                clock,
    input logic                reset,
    reorder_buffer_mw_if.slave rob
);
    localparam int DEPTH = 1 << ROB_ADDR_WIDTH;
    localparam int AW    = ROB_ADDR_WIDTH;
    localparam int PW    = ROB_ADDR_WIDTH + 1;
    localparam int RW    = REG_ADDR_WIDTH;
    localparam int XW    = ARCH_ADDR_WIDTH;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ROLLBACK = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d, walk_q, walk_d, stop_q, stop_d;
    logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d;
`ifdef ROB_EXCEPTION_EN
    logic [DEPTH-1:0] exc_q, exc_d;
`endif
    logic [XW-1:0]    arch_q [DEPTH];
    logic [XW-1:0]    arch_d [DEPTH];
    logic [RW-1:0]    dest_q [DEPTH];
    logic [RW-1:0]    dest_d [DEPTH];
    logic [RW-1:0]    old_q  [DEPTH];
    logic [RW-1:0]    old_d  [DEPTH];

    logic [AW-1:0]    head_idx_s, tail_idx_s, walk_idx_s, flush_age_s;
    logic [PW-1:0]    count_s, free_s, alloc_cnt_s, retire_cnt_s, squash_age_s;
    logic             idle_s, exc_hit_s, flush_hit_s, flush_take_s, alloc_ready_s, retire_run_s;
    logic [RETIRE_WIDTH-1:0] retire_ok_s;
    logic [AW-1:0]    comp_tag_s [COMPLETE_PORTS];
    logic [XW-1:0]    al_arch_s  [DISPATCH_WIDTH];
    logic [RW-1:0]    al_dest_s  [DISPATCH_WIDTH];
    logic [RW-1:0]    al_old_s   [DISPATCH_WIDTH];

    // Distance of a tag from the head, i.e. its age in program order (0 = oldest).
    function automatic logic [AW-1:0] age_f(input logic [AW-1:0] tag, input logic [AW-1:0] head);
        return tag - head;
    endfunction

    // Unpack per-slot request fields.
    always_comb begin
        alloc_cnt_s = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            al_arch_s[i] = rob.alloc_arch[i*XW +: XW];
            al_dest_s[i] = rob.alloc_dest[i*RW +: RW];
            al_old_s[i]  = rob.alloc_old_dest[i*RW +: RW];
            alloc_cnt_s  = alloc_cnt_s + PW'(rob.alloc_valid[i]);
        end
        for (int c = 0; c < COMPLETE_PORTS; c++) begin
            comp_tag_s[c] = rob.complete_tag[c*AW +: AW];
        end
    end

    // Occupancy, flush qualification and the allocation handshake.
    always_comb begin
        head_idx_s  = head_q[AW-1:0];
        tail_idx_s  = tail_q[AW-1:0];
        walk_idx_s  = walk_q[AW-1:0];
        count_s     = tail_q - head_q;
        free_s      = PW'(DEPTH) - count_s;
        idle_s      = (state_q == ST_IDLE);
`ifdef ROB_EXCEPTION_EN
        exc_hit_s   = idle_s && valid_q[head_idx_s] && done_q[head_idx_s] && exc_q[head_idx_s];
`else
        exc_hit_s   = 1'b0;
`endif
        flush_age_s  = age_f(rob.flush_tag, head_idx_s);
        flush_hit_s  = idle_s && !exc_hit_s && rob.flush_valid && valid_q[rob.flush_tag];
        // Flushing the youngest entry leaves nothing to squash.
        flush_take_s = flush_hit_s && ((PW'(flush_age_s) + PW'(1'b1)) != count_s);
        alloc_ready_s = idle_s && !rob.flush_valid && !exc_hit_s && (free_s >= PW'(DISPATCH_WIDTH));
        if (!idle_s) begin
            squash_age_s = stop_q - head_q;
        end else if (flush_take_s) begin
            squash_age_s = PW'(flush_age_s) + PW'(1'b1);
        end else begin
            squash_age_s = PW'(DEPTH);
        end
    end

    // In-order retire window: a slot retires only if every older slot in the window does.
    always_comb begin
        retire_run_s        = idle_s && !rob.flush_valid && !exc_hit_s;
        retire_cnt_s        = '0;
        retire_ok_s         = '0;
        rob.retire_arch     = '0;
        rob.retire_dest     = '0;
        rob.retire_old_dest = '0;
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            retire_run_s = retire_run_s && valid_q[head_idx_s + AW'(k)] && done_q[head_idx_s + AW'(k)]
`ifdef ROB_EXCEPTION_EN
                           && !exc_q[head_idx_s + AW'(k)]
`endif
                           ;
            retire_ok_s[k] = retire_run_s;
            retire_cnt_s   = retire_cnt_s + PW'(retire_run_s);
            rob.retire_arch[k*XW +: XW]     = arch_q[head_idx_s + AW'(k)];
            rob.retire_dest[k*RW +: RW]     = dest_q[head_idx_s + AW'(k)];
            rob.retire_old_dest[k*RW +: RW] = old_q[head_idx_s + AW'(k)];
        end
    end

    // Output wiring for tags, rollback presentation and status.
    always_comb begin
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            rob.alloc_tag[i*AW +: AW] = tail_idx_s + AW'(i);
        end
        rob.alloc_ready  = alloc_ready_s;
        rob.retire_valid = retire_ok_s;
        rob.rb_valid     = !idle_s;
        rob.rb_arch      = arch_q[walk_idx_s];
        rob.rb_dest      = dest_q[walk_idx_s];
        rob.rb_old_dest  = old_q[walk_idx_s];
        rob.rolling_back = !idle_s;
        rob.count        = count_s;
        rob.empty        = (head_q == tail_q);
        rob.full         = (head_idx_s == tail_idx_s) && (head_q[AW] != tail_q[AW]);
`ifdef ROB_EXCEPTION_EN
        rob.exc_valid    = exc_hit_s;
        rob.exc_tag      = head_idx_s;
`endif
    end

    // Next-state: completions, retirement, then FSM (flush/exception/alloc or rollback walk).
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        walk_d  = walk_q;
        stop_d  = stop_q;
        valid_d = valid_q;
        done_d  = done_q;
`ifdef ROB_EXCEPTION_EN
        exc_d   = exc_q;
`endif
        arch_d  = arch_q;
        dest_d  = dest_q;
        old_d   = old_q;

        for (int c = 0; c < COMPLETE_PORTS; c++) begin
            if (rob.complete_valid[c] && valid_q[comp_tag_s[c]] &&
                ({1'b0, age_f(comp_tag_s[c], head_idx_s)} < squash_age_s)) begin
                done_d[comp_tag_s[c]] = 1'b1;
`ifdef ROB_EXCEPTION_EN
                exc_d[comp_tag_s[c]]  = exc_d[comp_tag_s[c]] | rob.complete_exc[c];
`endif
            end else begin
                done_d[comp_tag_s[c]] = done_d[comp_tag_s[c]];
            end
        end

        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            if (retire_ok_s[k]) begin
                valid_d[head_idx_s + AW'(k)] = 1'b0;
                done_d[head_idx_s + AW'(k)]  = 1'b0;
            end else begin
                valid_d[head_idx_s + AW'(k)] = valid_d[head_idx_s + AW'(k)];
            end
        end
        head_d = head_q + retire_cnt_s;

        case (state_q)
            ST_IDLE: begin
                if (exc_hit_s) begin
                    state_d = ST_ROLLBACK;
                    stop_d  = head_q;
                    walk_d  = tail_q - PW'(1'b1);
                end else if (flush_take_s) begin
                    state_d = ST_ROLLBACK;
                    stop_d  = head_q + PW'(flush_age_s) + PW'(1'b1);
                    walk_d  = tail_q - PW'(1'b1);
                end else if (alloc_ready_s) begin
                    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
                        if (rob.alloc_valid[i]) begin
                            valid_d[tail_idx_s + AW'(i)] = 1'b1;
                            done_d[tail_idx_s + AW'(i)]  = 1'b0;
`ifdef ROB_EXCEPTION_EN
                            exc_d[tail_idx_s + AW'(i)]   = 1'b0;
`endif
                            arch_d[tail_idx_s + AW'(i)]  = al_arch_s[i];
                            dest_d[tail_idx_s + AW'(i)]  = al_dest_s[i];
                            old_d[tail_idx_s + AW'(i)]   = al_old_s[i];
                        end else begin
                            valid_d[tail_idx_s + AW'(i)] = valid_d[tail_idx_s + AW'(i)];
                        end
                    end
                    tail_d = tail_q + alloc_cnt_s;
                end else begin
                    tail_d = tail_q;
                end
            end
            ST_ROLLBACK: begin
                valid_d[walk_idx_s] = 1'b0;
                done_d[walk_idx_s]  = 1'b0;
`ifdef ROB_EXCEPTION_EN
                exc_d[walk_idx_s]   = 1'b0;
`endif
                tail_d = walk_q;
                if (walk_q == stop_q) begin
                    state_d = ST_IDLE;
                end else begin
                    walk_d = walk_q - PW'(1'b1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            walk_q  <= '0;
            stop_q  <= '0;
            valid_q <= '0;
            done_q  <= '0;
`ifdef ROB_EXCEPTION_EN
            exc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            walk_q  <= walk_d;
            stop_q  <= stop_d;
            valid_q <= valid_d;
            done_q  <= done_d;
`ifdef ROB_EXCEPTION_EN
            exc_q   <= exc_d;
`endif
        end
    end

    // Payload storage; contents are qualified by valid_q so it needs no reset.
    always_ff @(posedge clock) begin
        arch_q <= arch_d;
        dest_q <= dest_d;
        old_q  <= old_d;
    end
endmodule

// File: tb/tb_reorder_buffer_mw.sv
// Scoreboard bench for reorder_buffer_mw: a queue-based program-order model predicts retirements,
// rollback presentations and occupancy; a separate monitor compares DUT outputs against them.
module tb_reorder_buffer_mw;
    logic clock = 1'b0;
    logic reset;

    reorder_buffer_mw_if bus ();
    reorder_buffer_mw dut (.clock(clock), .reset(reset), .rob(bus));

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0] tag;
        logic [4:0] arch;
        logic [6:0] dest;
        logic [6:0] old;
        bit         done;
    } ent_t;

    ent_t rob_m[$];   // in-flight instructions, oldest first
    ent_t ret_q[$];   // expected retirements
    ent_t rb_q[$];    // expected rollback presentations
    int   rb_left  = 0;
    int   next_tag = 0;
    int   checks   = 0;
    int   fails    = 0;
    bit   mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.alloc_valid    = 2'b00;
        bus.alloc_arch     = 10'd0;
        bus.alloc_dest     = 14'd0;
        bus.alloc_old_dest = 14'd0;
        bus.complete_valid = 2'b00;
        bus.complete_tag   = 10'd0;
        bus.flush_valid    = 1'b0;
        bus.flush_tag      = 5'd0;
`ifdef ROB_EXCEPTION_EN
        bus.complete_exc   = 2'b00;
`endif
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a retirement or rollback entry.
    initial begin
        ent_t e;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                for (int k = 0; k < 2; k++) begin
                    if (bus.retire_valid[k]) begin
                        if (ret_q.size() == 0) begin
                            checks++; fails++;
                            $display("FAIL retire_unexpected: slot %0d retired, expected none", k);
                        end else begin
                            e = ret_q.pop_front();
                            check("retire_arch", 32'(bus.retire_arch[k*5 +: 5]), 32'(e.arch));
                            check("retire_dest", 32'(bus.retire_dest[k*7 +: 7]), 32'(e.dest));
                            check("retire_old_dest", 32'(bus.retire_old_dest[k*7 +: 7]), 32'(e.old));
                        end
                    end
                end
                if (bus.rb_valid) begin
                    if (rb_q.size() == 0) begin
                        checks++; fails++;
                        $display("FAIL rb_unexpected: rollback entry presented, expected none");
                    end else begin
                        e = rb_q.pop_front();
                        check("rb_arch", 32'(bus.rb_arch), 32'(e.arch));
                        check("rb_dest", 32'(bus.rb_dest), 32'(e.dest));
                        check("rb_old_dest", 32'(bus.rb_old_dest), 32'(e.old));
                    end
                end
            end
        end
    end

    // One clock of stimulus; expectations come from the program-order model.
    task automatic step(input logic [1:0] av, input logic [1:0] cv, input logic [4:0] ct0,
                        input logic [4:0] ct1, input logic fv, input logic [4:0] ft);
        int   nret;
        int   cnt;
        int   j;
        bit   idle;
        bit   ar;
        logic [4:0] ctag;
        logic [4:0] a_arch [2];
        logic [6:0] a_dest [2];
        logic [6:0] a_old  [2];
        ent_t e;
        idle = (rb_left == 0);
        cnt  = rob_m.size() + rb_left;
        nret = 0;
        if (idle && !fv) begin
            while (nret < 2 && nret < rob_m.size() && rob_m[nret].done) nret++;
        end
        ar = idle && !fv && ((32 - cnt) >= 2);
        for (int i = 0; i < 2; i++) begin
            a_arch[i] = 5'($urandom);
            a_dest[i] = 7'($urandom);
            a_old[i]  = 7'($urandom);
        end
        bus.alloc_valid    = av;
        bus.alloc_arch     = {a_arch[1], a_arch[0]};
        bus.alloc_dest     = {a_dest[1], a_dest[0]};
        bus.alloc_old_dest = {a_old[1], a_old[0]};
        bus.complete_valid = cv;
        bus.complete_tag   = {ct1, ct0};
        bus.flush_valid    = fv;
        bus.flush_tag      = ft;
        for (int i = 0; i < nret; i++) ret_q.push_back(rob_m[i]);

        @(negedge clock);
        #1;
        check("alloc_ready", 32'(bus.alloc_ready), 32'(ar));
        check("count", 32'(bus.count), 32'(cnt));
        check("empty", 32'(bus.empty), 32'(cnt == 0));
        check("full", 32'(bus.full), 32'(cnt == 32));
        check("rolling_back", 32'(bus.rolling_back), 32'(!idle));
        check("rb_valid", 32'(bus.rb_valid), 32'(!idle));
        if (ar) begin
            for (int i = 0; i < 2; i++) begin
                check("alloc_tag", 32'(bus.alloc_tag[i*5 +: 5]), 32'((next_tag + i) % 32));
            end
        end

        // Model update for the coming edge.
        for (int i = 0; i < nret; i++) void'(rob_m.pop_front());
        if (!idle) begin
            rb_left--;
        end else if (fv) begin
            j = -1;
            foreach (rob_m[q]) if (rob_m[q].tag == ft) j = q;
            if (j >= 0 && j < rob_m.size() - 1) begin
                while (rob_m.size() > j + 1) begin
                    rb_q.push_back(rob_m.pop_back());
                    rb_left++;
                end
                next_tag = (int'(ft) + 1) % 32;
            end
        end
        for (int c = 0; c < 2; c++) begin
            ctag = (c == 0) ? ct0 : ct1;
            if (cv[c]) foreach (rob_m[q]) if (rob_m[q].tag == ctag) rob_m[q].done = 1'b1;
        end
        if (ar) begin
            for (int i = 0; i < 2; i++) begin
                if (av[i]) begin
                    e.tag  = 5'(next_tag);
                    e.arch = a_arch[i];
                    e.dest = a_dest[i];
                    e.old  = a_old[i];
                    e.done = 1'b0;
                    rob_m.push_back(e);
                    next_tag = (next_tag + 1) % 32;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        reset  = 1'b1;
        idle_inputs();
        @(negedge clock);
        #1;
        rob_m.delete();
        ret_q.delete();
        rb_q.delete();
        rb_left  = 0;
        next_tag = 0;
        @(posedge clock);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
    endtask

    function automatic logic [4:0] pick_tag();
        if (rob_m.size() > 0 && ($urandom % 4) != 0) return rob_m[$urandom % rob_m.size()].tag;
        return 5'($urandom);
    endfunction

    initial begin
        logic [1:0] av;
        int guard;
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clock);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Reset state, then fill to full with 2 per cycle.
        step(2'b00, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0);
        repeat (16) step(2'b11, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0);
        step(2'b11, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0);

        // Out-of-order completion, in-order retirement.
        do_reset();
        repeat (2) step(2'b11, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0);
        step(2'b00, 2'b11, 5'd1, 5'd0, 1'b0, 5'd0);
        step(2'b00, 2'b01, 5'd3, 5'd0, 1'b0, 5'd0);
        repeat (2) step(2'b00, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0);
        step(2'b00, 2'b01, 5'd2, 5'd0, 1'b0, 5'd0);
        repeat (2) step(2'b00, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0);

        // Flush at tag 3 with 8 entries; alloc in the flush cycle is dropped.
        do_reset();
        repeat (4) step(2'b11, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0);
        step(2'b11, 2'b00, 5'd0, 5'd0, 1'b1, 5'd3);
        step(2'b11, 2'b01, 5'd6, 5'd0, 1'b0, 5'd0);
        step(2'b00, 2'b01, 5'd1, 5'd0, 1'b1, 5'd0);
        repeat (3) step(2'b00, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0);

        // Reset in the middle of a rollback.
        do_reset();
        repeat (4) step(2'b11, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0);
        step(2'b00, 2'b00, 5'd0, 5'd0, 1'b1, 5'd1);
        step(2'b00, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0);
        do_reset();
        step(2'b00, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0);

        // Randomized traffic with wrap-around, flushes and stray completions.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            case ($urandom % 3)
                0:       av = 2'b00;
                1:       av = 2'b01;
                default: av = 2'b11;
            endcase
            step(av, 2'($urandom), pick_tag(), pick_tag(), ($urandom % 24) == 0, pick_tag());
        end

        // Drain: finish any rollback and complete everything left.
        guard = 0;
        while ((rob_m.size() > 0 || rb_left > 0) && guard < 200) begin
            step(2'b00, 2'b11, (rob_m.size() > 0) ? rob_m[0].tag : 5'd0,
                 (rob_m.size() > 1) ? rob_m[1].tag : 5'd0, 1'b0, 5'd0);
            guard++;
        end
        step(2'b00, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0);
        check("drain_model_empty", 32'(rob_m.size() + rb_left), 32'd0);
        check("ret_q_empty", 32'(ret_q.size()), 32'd0);
        check("rb_q_empty", 32'(rb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end
endmodule
